// File: rtl/dmem_access_unit.sv
// Memory-stage data-memory access unit: turns a load/store in M into one req/ack bus transaction and stalls the pipeline until it completes.
// Optional bus timeout abort is compiled in when DMEM_TIMEOUT_EN is defined.
module dmem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic              MemtoRegM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              MisalignM,
    output logic              BusErrM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    // Bus handshake: mem_req rises with addr/we/wdata valid and holds them stable
    // until the single-cycle mem_ack strobe; mem_ack/mem_rdata are only honoured in BUSY.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              acc, mis;

    // A non-positive TIMEOUT would make the abort compare meaningless.
    if (TIMEOUT < 1) begin : g_timeout_must_be_positive
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             buserr_q, buserr_d;
    assign BusErrM = buserr_q;
`else
    assign BusErrM = 1'b0;
`endif

    assign acc       = MemWriteM | MemtoRegM;
    assign mis       = acc & (ALUOutM[1:0] != 2'b00);
    assign MisalignM = mis;
    assign StallM    = ((state_q == IDLE) & acc & ~mis) | (state_q == BUSY);

    assign ReadDataM = rdata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef DMEM_TIMEOUT_EN
        cnt_d    = '0;
        buserr_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (acc & ~mis) begin
                    addr_d  = {ALUOutM[ADDR_W-1:2], 2'b00};
                    wdata_d = WriteDataM;
                    we_d    = MemWriteM;
                    req_d   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = mem_rdata;
                    state_d = DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d    = 1'b0;
                    if (!we_q) rdata_d = DATA_W'(32'hDEADBEEF);
                    buserr_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q    <= '0;
            buserr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
            buserr_q <= buserr_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed scenarios then random load/store traffic against a transaction-level model.
module tb_dmem_access_unit;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          MemWriteM = 1'b0;
    logic          MemtoRegM = 1'b0;
    logic [AW-1:0] ALUOutM = '0;
    logic [DW-1:0] WriteDataM = '0;
    logic [DW-1:0] ReadDataM;
    logic          StallM, MisalignM, BusErrM;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    dbg_state;

    dmem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard and model state
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_rdata = '0;
    logic [AW-1:0] model_addr  = '0;
    logic [DW-1:0] model_wdata = '0;
    logic          model_we    = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one M-stage instruction and holds it until the pipeline advances.
    // Called 1 time unit after a rising edge; returns at the same phase after the DONE cycle.
    task automatic do_op(input bit st, input bit ld, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int delay,
                         input logic [DW-1:0] rd, input bit never_ack);
        bit            acc, mis, finished;
        int            stalls, req_cycles, exp_stalls;
        logic [DW-1:0] exp_rd;
        MemWriteM  = st;
        MemtoRegM  = ld;
        ALUOutM    = addr;
        WriteDataM = wd;
        mem_ack    = 1'b0;
        acc = st | ld;
        mis = acc && (addr[1:0] != 2'b00);
        if (!acc || mis) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(negedge clk);
            check("no_access_stall", StallM, 0);
            check("misalign_flag", MisalignM, mis);
            check("no_access_req", mem_req, 0);
            check("bus_addr_hold", mem_addr, model_addr);
            next_cycle();
            mem_ack = 1'b0;
            check("no_access_rdata", ReadDataM, model_rdata);
            return;
        end
        model_addr  = {addr[AW-1:2], 2'b00};
        model_we    = st;
        model_wdata = wd;
        if (!st) exp_q.push_back(never_ack ? 32'hDEADBEEF : rd);
        exp_stalls = never_ack ? TO + 1 : delay + 1;
        stalls     = 0;
        req_cycles = 0;
        finished   = 1'b0;
        for (int c = 0; c < exp_stalls + 40; c++) begin
            if (c >= 1) begin
                mem_ack   = !never_ack && (c == delay);
                mem_rdata = (c == delay) ? rd : $urandom;
            end
            @(negedge clk);
            if (!StallM) begin
                finished = 1'b1;
                break;
            end
            stalls++;
            if (mem_req) begin
                req_cycles++;
                check("busy_addr", mem_addr, model_addr);
                check("busy_we", mem_we, model_we);
                check("busy_wdata", mem_wdata, model_wdata);
            end
            next_cycle();
            mem_ack = 1'b0;
        end
        mem_ack = 1'b0;
        check("access_completed", finished, 1);
        check("stall_cycles", stalls, exp_stalls);
        check("req_cycles", req_cycles, exp_stalls - 1);
        check("done_req_low", mem_req, 0);
        check("done_buserr", BusErrM, never_ack);
        if (!st && exp_q.size() > 0) model_rdata = exp_q.pop_front();
        check("done_rdata", ReadDataM, model_rdata);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind;
        logic [AW-1:0] a;
        // Reset values
        #12;
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", ReadDataM, 0);
        check("rst_buserr", BusErrM, 0);
        check("rst_stall", StallM, 0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // Directed scenarios
        do_op(0, 1, 32'h100, 32'h0, 1, 32'h12345678, 0);
        check("read1_value", ReadDataM, 32'h12345678);
        do_op(1, 0, 32'h2C, 32'hCAFEF00D, 4, 32'h0BADF00D, 0);
        do_op(0, 1, 32'h103, 32'h0, 1, 32'h0, 0);
        do_op(0, 1, 32'h0, 32'h0, 1, 32'hA5A5_0000, 0);
        do_op(0, 1, 32'h4, 32'h0, 1, 32'h0000_5A5A, 0);
        do_op(0, 0, 32'h8, 32'h0, 1, 32'h0, 0);
        do_op(1, 1, 32'h40, 32'h1357_9BDF, 2, 32'hFFFF_FFFF, 0);
        do_op(1, 0, 32'h41, 32'h1111_2222, 1, 32'h0, 0);

        // Reset two cycles into BUSY, ack arrives after release
        MemtoRegM = 1'b1;
        MemWriteM = 1'b0;
        ALUOutM   = 32'h200;
        next_cycle();
        next_cycle();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_req", mem_req, 0);
        check("async_rst_state", dbg_state, 0);
        check("async_rst_rdata", ReadDataM, 0);
        MemtoRegM = 1'b0;
        next_cycle();
        reset = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_8888;
        @(negedge clk);
        check("post_rst_req", mem_req, 0);
        check("post_rst_stall", StallM, 0);
        next_cycle();
        mem_ack = 1'b0;
        check("post_rst_rdata", ReadDataM, 0);
        model_rdata = '0;
        model_addr  = '0;
        model_wdata = '0;
        model_we    = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        do_op(0, 1, 32'h300, 32'h0, 1, 32'h0, 1);
        @(negedge clk);
        check("buserr_one_cycle", BusErrM, 0);
        next_cycle();
`endif

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            a = $urandom;
            if (kind == 0) begin
                do_op(0, 0, a, $urandom, 1, 32'h0, 0);
            end else if (kind == 1) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
                do_op(1'($urandom_range(0, 1)), 1'b1, a, $urandom, 1, 32'h0, 0);
            end else begin
                a[1:0] = 2'b00;
                do_op(kind >= 6, (kind < 6) || (kind == 9), a, $urandom,
                      $urandom_range(1, 6), $urandom, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
